wb_port_arbiter: RTL



---
 rtl/wb_port_arbiter_pkg.sv | 47 ++++
 rtl/wb_port_arbiter_if.sv | 55 +++++
 rtl/wb_arb_fifo.sv | 86 ++++++++
 rtl/wb_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter_pkg
//  Description : Shared types and field layout for the register-file write
//                port arbiter. Contains the long-latency queue entry layout
//                {pc, dest, data}, the write-back slot bus layout
//                {valid, pc, dest, result, we}, the writer-select encoding
//                and a one-hot destination helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    // Long-latency queue entry: pc[68:37], dest[36:32], data[31:0]
    localparam int WBARB_ENTRY_W  = 69;
    localparam int WBARB_DATA_LSB = 0;
    localparam int WBARB_DEST_LSB = 32;
    localparam int WBARB_PC_LSB   = 37;

    // MEM->WB slot bus: valid + pc + dest + result + we
    localparam int WBARB_TO_WB_W  = 71;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] data;
    } lu_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        we;
    } wb_slot_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_SLOT = 2'd1,
        SEL_FIFO = 2'd2
    } wb_sel_e;

    function automatic logic [31:0] dest_onehot(input logic [4:0] dest);
        dest_onehot = 32'd1 << dest;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter_if
//  Description : Bus bundle for the write-port arbiter.
//                Pipeline side : pipe_valid/pc/dest/result/we -> pipe_allow_in
//                LU side       : lu_valid/pc/dest/result      -> lu_ready
//                RF side       : rf_we, rf_waddr, rf_wdata, pend_mask
//                Debug trace   : debug_wb_pc/rf_we/rf_wnum/rf_wdata
//                modport master : environment (drives MEM/LU, sees RF port)
//                modport slave  : arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
    logic        pipe_valid;
    logic [31:0] pipe_pc;
    logic [4:0]  pipe_dest;
    logic [31:0] pipe_result;
    logic        pipe_we;
    logic        pipe_allow_in;

    logic        lu_valid;
    logic [31:0] lu_pc;
    logic [4:0]  lu_dest;
    logic [31:0] lu_result;
    logic        lu_ready;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;

    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    modport master (
        output pipe_valid, pipe_pc, pipe_dest, pipe_result, pipe_we,
        input  pipe_allow_in,
        output lu_valid, lu_pc, lu_dest, lu_result,
        input  lu_ready,
        input  rf_we, rf_waddr, rf_wdata, pend_mask,
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    modport slave (
        input  pipe_valid, pipe_pc, pipe_dest, pipe_result, pipe_we,
        output pipe_allow_in,
        input  lu_valid, lu_pc, lu_dest, lu_result,
        output lu_ready,
        output rf_we, rf_waddr, rf_wdata, pend_mask,
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface
`default_nettype wire

// File: rtl/wb_arb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_fifo
//  Description : Small synchronous FIFO for long-latency results. Exposes a
//                per-entry valid bit and a per-entry key field (destination
//                register) so the parent can build a pending mask.
//                Ports: clk, resetn (async active-low), i_push/i_push_data,
//                i_pop, o_head_data, o_full, o_empty, o_entry_valid,
//                o_entry_key.
//                Push while full and pop while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_fifo #(
    parameter int DEPTH   = 2,
    parameter int WIDTH   = 69,
    parameter int KEY_LSB = 32,
    parameter int KEY_W   = 5
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_push_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_head_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [DEPTH-1:0]            o_entry_valid,
    output logic [DEPTH-1:0][KEY_W-1:0] o_entry_key
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [DEPTH-1:0]   r_valid;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Pointers are log2(DEPTH) wide, so increment wraps naturally.
            // Clear-before-set keeps the valid bits right when a pop and a
            // push hit the same cycle.
            if (w_do_pop) begin
                r_rd_ptr          <= r_rd_ptr + 1'b1;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_do_push) begin
                r_mem[r_wr_ptr]   <= i_push_data;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_valid[r_wr_ptr] <= 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data   = r_mem[r_rd_ptr];
    assign o_entry_valid = r_valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_key
        assign o_entry_key[g] = r_mem[g][KEY_LSB +: KEY_W];
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Owner of the register-file write port. Holds the MEM->WB
//                slot, queues long-latency results in wb_arb_fifo, picks one
//                writer per cycle and drives the RF write port, debug trace
//                and pending-destination mask.
//                Ports: clk, resetn (async active-low), bus (slave modport of
//                wb_port_arbiter_if: pipe_*, lu_*, rf_*, pend_mask, debug_*).
//                Parameters: FIFO_DEPTH (power of two, >=2),
//                STARVE_LIMIT (1..15).
//                Build option: define WBARB_STARVE_GUARD_EN to enable the
//                starvation counter that forces a queue grant after
//                STARVE_LIMIT consecutive slot writes; otherwise the slot
//                has strict priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    wb_port_arbiter_if.slave  bus
);

    logic [WBARB_TO_WB_W-1:0] r_slot;
    wb_slot_t                 w_slot;

    logic [WBARB_ENTRY_W-1:0] w_push_data;
    logic [WBARB_ENTRY_W-1:0] w_fifo_head;
    lu_entry_t                w_head;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [FIFO_DEPTH-1:0]    w_entry_valid;
    logic [FIFO_DEPTH-1:0][4:0] w_entry_dest;

    logic                     w_push;
    logic                     w_force;
    logic                     w_fifo_pop;
    logic                     w_slot_retire;
    logic                     w_allow_in;
    wb_sel_e                  w_sel;

    logic                     w_rf_we;
    logic [4:0]               w_rf_waddr;
    logic [31:0]              w_rf_wdata;
    logic [31:0]              w_wb_pc;
    logic [31:0]              w_pend_mask;

    assign w_slot = wb_slot_t'(r_slot);
    assign w_head = lu_entry_t'(w_fifo_head);

    // ------------------------------------------------------------------
    // Long-latency queue
    // ------------------------------------------------------------------
    always_comb begin
        w_push_data = '0;
        w_push_data[WBARB_PC_LSB   +: 32] = bus.lu_pc;
        w_push_data[WBARB_DEST_LSB +: 5]  = bus.lu_dest;
        w_push_data[WBARB_DATA_LSB +: 32] = bus.lu_result;
    end

    assign w_push = bus.lu_valid & ~w_fifo_full;

    wb_arb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (WBARB_ENTRY_W),
        .KEY_LSB (WBARB_DEST_LSB),
        .KEY_W   (5)
    ) u_fifo (
        .clk           (clk),
        .resetn        (resetn),
        .i_push        (w_push),
        .i_push_data   (w_push_data),
        .i_pop         (w_fifo_pop),
        .o_head_data   (w_fifo_head),
        .o_full        (w_fifo_full),
        .o_empty       (w_fifo_empty),
        .o_entry_valid (w_entry_valid),
        .o_entry_key   (w_entry_dest)
    );

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef WBARB_STARVE_GUARD_EN
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    // Counts consecutive slot writes that bypassed a non-empty queue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (w_fifo_pop || w_fifo_empty) begin
            r_starve_cnt <= '0;
        end else if (w_sel == SEL_SLOT && w_slot.we) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign w_force = ~w_fifo_empty & (r_starve_cnt == c_STARVE_LIMIT);
`else
    logic [3:0] w_unused_limit;
    assign w_unused_limit = 4'(STARVE_LIMIT);
    assign w_force        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Writer selection
    // ------------------------------------------------------------------
    always_comb begin
        w_sel         = SEL_NONE;
        w_slot_retire = 1'b0;
        w_fifo_pop    = 1'b0;
        if (w_slot.valid) begin
            if (!w_slot.we) begin
                // Slot needs no write port: retire it and let the queue use
                // the port in the same cycle.
                w_slot_retire = 1'b1;
                if (!w_fifo_empty) begin
                    w_fifo_pop = 1'b1;
                    w_sel      = SEL_FIFO;
                end else begin
                    w_sel      = SEL_SLOT;
                end
            end else if (w_force) begin
                w_fifo_pop = 1'b1;
                w_sel      = SEL_FIFO;
            end else begin
                w_slot_retire = 1'b1;
                w_sel         = SEL_SLOT;
            end
        end else if (!w_fifo_empty) begin
            w_fifo_pop = 1'b1;
            w_sel      = SEL_FIFO;
        end
    end

    // Writes to r0 still consume the grant but never assert the enable.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = '0;
        w_rf_wdata = '0;
        w_wb_pc    = '0;
        case (w_sel)
            SEL_SLOT: begin
                w_rf_we    = w_slot.we & (w_slot.dest != 5'd0);
                w_rf_waddr = w_slot.dest;
                w_rf_wdata = w_slot.result;
                w_wb_pc    = w_slot.pc;
            end
            SEL_FIFO: begin
                w_rf_we    = (w_head.dest != 5'd0);
                w_rf_waddr = w_head.dest;
                w_rf_wdata = w_head.data;
                w_wb_pc    = w_head.pc;
            end
            default: begin
                w_rf_we    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write-back slot
    // ------------------------------------------------------------------
    assign w_allow_in = ~w_slot.valid | w_slot_retire;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_slot <= '0;
        end else if (bus.pipe_valid && w_allow_in) begin
            r_slot <= {1'b1, bus.pipe_pc, bus.pipe_dest, bus.pipe_result, bus.pipe_we};
        end else if (w_slot_retire) begin
            r_slot[WBARB_TO_WB_W-1] <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending-destination mask
    // ------------------------------------------------------------------
    always_comb begin
        w_pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_pend_mask = w_pend_mask | dest_onehot(w_entry_dest[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pipe_allow_in     = w_allow_in;
    assign bus.lu_ready          = ~w_fifo_full;
    assign bus.rf_we             = w_rf_we;
    assign bus.rf_waddr          = w_rf_waddr;
    assign bus.rf_wdata          = w_rf_wdata;
    assign bus.pend_mask         = w_pend_mask;
    assign bus.debug_wb_pc       = w_wb_pc;
    assign bus.debug_wb_rf_we    = {4{w_rf_we}};
    assign bus.debug_wb_rf_wnum  = w_rf_waddr;
    assign bus.debug_wb_rf_wdata = w_rf_wdata;

endmodule
`default_nettype wire
